// File: rtl/fb_pkg.sv
// ----------------------------------------------------------------------------
// fb_pkg
// Shared types for the framebuffer memory arbiter slice.
//   chunk_t      8 x 16-bit RGB565 pixels, pixel 0 in bits [15:0]
//   strb_t       16 byte enables for one chunk
//   mem_cmd_e    memory command kind (write = 0, read = 1)
//   arb_state_e  arbiter mode: normal arbitration or framebuffer clear sweep
//   MEM_ADDR_W   width of the memory controller chunk address
// ----------------------------------------------------------------------------
package fb_pkg;

    localparam int MEM_ADDR_W = 27;

    typedef logic [7:0][15:0] chunk_t;
    typedef logic [15:0]      strb_t;

    typedef enum logic {
        CMD_WR = 1'b0,
        CMD_RD = 1'b1
    } mem_cmd_e;

    typedef enum logic {
        S_ARB   = 1'b0,
        S_CLEAR = 1'b1
    } arb_state_e;

    // Replicates one pixel across a whole chunk.
    function automatic chunk_t fill_chunk(input logic [15:0] pix);
        return {8{pix}};
    endfunction

endpackage

// File: rtl/fb_cmd_reg.sv
// ----------------------------------------------------------------------------
// fb_cmd_reg
// One-entry valid/ready command register in front of the memory controller.
// A command is loaded only when the slot is free; it then holds stable until
// the controller accepts it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture load_* into the slot (only legal when slot_free)
//   load_cmd/addr/wdata/wstrb   command being granted this cycle
//   cmd_ready       memory controller accepts the held command
//   slot_free       slot empty or draining this cycle
//   cmd_valid       held command valid
//   held_cmd/addr/wdata/wstrb   held command fields
// ----------------------------------------------------------------------------
module fb_cmd_reg
    import fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  mem_cmd_e              load_cmd,
    input  logic [MEM_ADDR_W-1:0] load_addr,
    input  chunk_t                load_wdata,
    input  strb_t                 load_wstrb,
    input  logic                  cmd_ready,
    output logic                  slot_free,
    output logic                  cmd_valid,
    output mem_cmd_e              held_cmd,
    output logic [MEM_ADDR_W-1:0] held_addr,
    output chunk_t                held_wdata,
    output strb_t                 held_wstrb
);

    assign slot_free = !cmd_valid || cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid  <= 1'b0;
            held_cmd   <= CMD_WR;
            held_addr  <= '0;
            held_wdata <= '0;
            held_wstrb <= '0;
        end else if (load) begin
            cmd_valid  <= 1'b1;
            held_cmd   <= load_cmd;
            held_addr  <= load_addr;
            held_wdata <= load_wdata;
            held_wstrb <= load_wstrb;
        end else if (cmd_ready) begin
            // Fields keep their last value; only valid drops when drained.
            cmd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// fb_mem_arbiter
// Shares the framebuffer memory command port between the stacker write-chunk
// stream and the scanout read-chunk stream. Round-robin between the two,
// urgent reads override, and a waiting write is forced through after
// STARVE_MAX consecutive urgent reads. One registered command per grant.
//
// Optional feature: define FB_CLEAR_EN to build the clear engine, which sweeps
// every chunk with {8{CLEAR_VALUE}} after a clear_start_in pulse.
//
// Ports:
//   clk_in, rst_n_in                     clock, asynchronous active-low reset
//   wr_valid_in/ready_out/addr_in/data_in/strobe_in   stacker write chunks
//   rd_valid_in/ready_out/addr_in, rd_urgent_in       scanout read requests
//   mem_valid_out/ready_in/cmd_out/addr_out/wdata_out/wstrb_out  memory port
//   clear_start_in, clear_busy_out, clear_done_out    clear engine control
// ----------------------------------------------------------------------------
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter  int          HRES        = 1280,
    parameter  int          VRES        = 720,
    parameter  int          STARVE_MAX  = 8,
    parameter  logic [15:0] CLEAR_VALUE = 16'h0,
    localparam int          NCHUNK      = HRES * VRES / 8,
    localparam int          CAW         = $clog2(NCHUNK)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  wr_valid_in,
    output logic                  wr_ready_out,
    input  logic [CAW-1:0]        wr_addr_in,
    input  logic [127:0]          wr_data_in,
    input  logic [15:0]           wr_strobe_in,
    input  logic                  rd_valid_in,
    output logic                  rd_ready_out,
    input  logic [CAW-1:0]        rd_addr_in,
    input  logic                  rd_urgent_in,
    output logic                  mem_valid_out,
    input  logic                  mem_ready_in,
    output logic                  mem_cmd_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out,
    output logic [127:0]          mem_wdata_out,
    output logic [15:0]           mem_wstrb_out,
    input  logic                  clear_start_in,
    output logic                  clear_busy_out,
    output logic                  clear_done_out
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                  slot_free;
    logic                  in_clear;
    logic                  force_wr;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  grant_clr;
    logic                  load;
    mem_cmd_e              load_cmd;
    logic [MEM_ADDR_W-1:0] load_addr;
    chunk_t                load_wdata;
    strb_t                 load_wstrb;
    mem_cmd_e              last_grant;
    mem_cmd_e              held_cmd;
    logic [SW-1:0]         starve_cnt;
    logic [CAW-1:0]        clear_ptr;

    // Grant selection. Nothing is granted unless the output slot can take it.
    always_comb begin
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        grant_clr = 1'b0;
        force_wr  = wr_valid_in && (starve_cnt == SW'(STARVE_MAX));
        if (slot_free) begin
            if (in_clear) begin
                // The sweep owns the port except when scanout is about to underrun.
                if (rd_urgent_in && rd_valid_in) grant_rd = 1'b1;
                else                             grant_clr = 1'b1;
            end else if (rd_urgent_in && rd_valid_in && !force_wr) begin
                grant_rd = 1'b1;
            end else if (force_wr) begin
                grant_wr = 1'b1;
            end else if (wr_valid_in && rd_valid_in) begin
                if (last_grant == CMD_RD) grant_wr = 1'b1;
                else                      grant_rd = 1'b1;
            end else if (wr_valid_in) begin
                grant_wr = 1'b1;
            end else if (rd_valid_in) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign wr_ready_out = grant_wr;
    assign rd_ready_out = grant_rd;
    assign load         = grant_wr || grant_rd || grant_clr;

    // Command assembly for whichever requester won; reads carry no data.
    always_comb begin
        load_cmd   = CMD_WR;
        load_addr  = MEM_ADDR_W'(wr_addr_in);
        load_wdata = wr_data_in;
        load_wstrb = wr_strobe_in;
        if (grant_rd) begin
            load_cmd   = CMD_RD;
            load_addr  = MEM_ADDR_W'(rd_addr_in);
            load_wdata = '0;
            load_wstrb = '0;
        end else if (grant_clr) begin
            load_addr  = MEM_ADDR_W'(clear_ptr);
            load_wdata = fill_chunk(CLEAR_VALUE);
            load_wstrb = 16'hFFFF;
        end
    end

    // Round-robin history and write starvation count. A read granted while a
    // write waits moves the write one step closer to being forced.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant <= CMD_RD;
            starve_cnt <= '0;
        end else if (grant_wr || grant_clr) begin
            last_grant <= CMD_WR;
            starve_cnt <= '0;
        end else if (grant_rd) begin
            last_grant <= CMD_RD;
            if (!wr_valid_in)                         starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))   starve_cnt <= starve_cnt + SW'(1);
        end else if (!wr_valid_in) begin
            starve_cnt <= '0;
        end
    end

`ifdef FB_CLEAR_EN
    arb_state_e state;

    // Clear sweep: a start pulse is only honoured while arbitrating normally,
    // and the sweep returns on its own after the last chunk is granted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= S_ARB;
            clear_ptr <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (clear_start_in) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (grant_clr) begin
                        if (clear_ptr == CAW'(NCHUNK - 1)) begin
                            state     <= S_ARB;
                            clear_ptr <= '0;
                        end else begin
                            clear_ptr <= clear_ptr + CAW'(1);
                        end
                    end
                end
                default: state <= S_ARB;
            endcase
        end
    end

    assign in_clear       = (state == S_CLEAR);
    assign clear_busy_out = (state == S_CLEAR);
    assign clear_done_out = grant_clr && (clear_ptr == CAW'(NCHUNK - 1));
`else
    logic unused_clear;

    assign unused_clear   = clear_start_in;
    assign clear_ptr      = '0;
    assign in_clear       = 1'b0;
    assign clear_busy_out = 1'b0;
    assign clear_done_out = 1'b0;
`endif

    fb_cmd_reg u_cmd_reg (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .load       (load),
        .load_cmd   (load_cmd),
        .load_addr  (load_addr),
        .load_wdata (load_wdata),
        .load_wstrb (load_wstrb),
        .cmd_ready  (mem_ready_in),
        .slot_free  (slot_free),
        .cmd_valid  (mem_valid_out),
        .held_cmd   (held_cmd),
        .held_addr  (mem_addr_out),
        .held_wdata (mem_wdata_out),
        .held_wstrb (mem_wstrb_out)
    );

    assign mem_cmd_out = held_cmd;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fb_mem_arbiter
// Directed self-checking bench for fb_mem_arbiter. With FB_CLEAR_EN defined
// the design is built with a tiny 16x4 framebuffer so the clear sweep is short.
// ----------------------------------------------------------------------------
module tb_fb_mem_arbiter;

`ifdef FB_CLEAR_EN
    localparam int HRES = 16;
    localparam int VRES = 4;
`else
    localparam int HRES = 1280;
    localparam int VRES = 720;
`endif
    localparam int          NCHUNK    = HRES * VRES / 8;
    localparam int          CAW       = $clog2(NCHUNK);
    localparam int          STARVE    = 8;
    localparam logic [15:0] CLEAR_PIX = 16'hF81F;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           wr_valid_in;
    logic           wr_ready_out;
    logic [CAW-1:0] wr_addr_in;
    logic [127:0]   wr_data_in;
    logic [15:0]    wr_strobe_in;
    logic           rd_valid_in;
    logic           rd_ready_out;
    logic [CAW-1:0] rd_addr_in;
    logic           rd_urgent_in;
    logic           mem_valid_out;
    logic           mem_ready_in;
    logic           mem_cmd_out;
    logic [26:0]    mem_addr_out;
    logic [127:0]   mem_wdata_out;
    logic [15:0]    mem_wstrb_out;
    logic           clear_start_in;
    logic           clear_busy_out;
    logic           clear_done_out;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_in = ~clk_in;

    fb_mem_arbiter #(
        .HRES        (HRES),
        .VRES        (VRES),
        .STARVE_MAX  (STARVE),
        .CLEAR_VALUE (CLEAR_PIX)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .wr_valid_in    (wr_valid_in),
        .wr_ready_out   (wr_ready_out),
        .wr_addr_in     (wr_addr_in),
        .wr_data_in     (wr_data_in),
        .wr_strobe_in   (wr_strobe_in),
        .rd_valid_in    (rd_valid_in),
        .rd_ready_out   (rd_ready_out),
        .rd_addr_in     (rd_addr_in),
        .rd_urgent_in   (rd_urgent_in),
        .mem_valid_out  (mem_valid_out),
        .mem_ready_in   (mem_ready_in),
        .mem_cmd_out    (mem_cmd_out),
        .mem_addr_out   (mem_addr_out),
        .mem_wdata_out  (mem_wdata_out),
        .mem_wstrb_out  (mem_wstrb_out),
        .clear_start_in (clear_start_in),
        .clear_busy_out (clear_busy_out),
        .clear_done_out (clear_done_out)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [CAW-1:0] wa,
                                 input logic [127:0] wd, input logic [15:0] ws,
                                 input logic rv, input logic [CAW-1:0] ra,
                                 input logic ru, input logic mr);
        wr_valid_in  = wv;
        wr_addr_in   = wa;
        wr_data_in   = wd;
        wr_strobe_in = ws;
        rd_valid_in  = rv;
        rd_addr_in   = ra;
        rd_urgent_in = ru;
        mem_ready_in = mr;
    endtask

    task automatic waitCycle;
        @(posedge clk_in);
        #1;
    endtask

    task automatic expectMem(input string tag, input logic v, input logic c,
                             input logic [26:0] a, input logic [127:0] d,
                             input logic [15:0] s);
        checkOutput({tag, " valid"}, 128'(mem_valid_out), 128'(v));
        checkOutput({tag, " cmd"},   128'(mem_cmd_out),   128'(c));
        checkOutput({tag, " addr"},  128'(mem_addr_out),  128'(a));
        checkOutput({tag, " wdata"}, mem_wdata_out,       d);
        checkOutput({tag, " wstrb"}, 128'(mem_wstrb_out), 128'(s));
    endtask

    task automatic expectReady(input string tag, input logic w, input logic r);
        checkOutput({tag, " wr_ready"}, 128'(wr_ready_out), 128'(w));
        checkOutput({tag, " rd_ready"}, 128'(rd_ready_out), 128'(r));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CAW-1:0] a_w, a_r, a4, a5, a6, a7, a8;
        logic [127:0]   d_w, d4, d5, d6, d7;
        logic           exp_rd;
        int             exp_ptr;

        a_w = CAW'(32'h0011);
        a_r = CAW'(32'h0022);
        a4  = CAW'(32'h1234);
        a5  = CAW'(32'h0005);
        a6  = CAW'(32'h0006);
        a7  = CAW'(32'h0007);
        a8  = CAW'(32'h0003);
        d_w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d4  = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
        d5  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        d6  = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;
        d7  = 128'h0F0F_F0F0_3C3C_C3C3_5A5A_A5A5_6969_9696;

        // Reset state
        rst_n_in       = 1'b0;
        clear_start_in = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        #12;
        expectMem("reset", 1'b0, 1'b0, 27'h0, 128'h0, 16'h0);
        expectReady("reset", 1'b0, 1'b0);
        checkOutput("reset busy", 128'(clear_busy_out), 128'(1'b0));
        checkOutput("reset done", 128'(clear_done_out), 128'(1'b0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        waitCycle();

        // Round robin: W,R,W,R... starting with W
        applyStimulus(1'b1, a_w, d_w, 16'hFFFF, 1'b1, a_r, 1'b0, 1'b1);
        exp_rd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            expectReady("rr", !exp_rd, exp_rd);
            waitCycle();
            checkOutput("rr cmd",   128'(mem_cmd_out),   128'(exp_rd));
            checkOutput("rr valid", 128'(mem_valid_out), 128'(1'b1));
            exp_rd = !exp_rd;
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();
        checkOutput("rr drain valid", 128'(mem_valid_out), 128'(1'b0));

        // Urgent reads with a waiting write: 8 reads then one forced write
        applyStimulus(1'b1, a_w, d_w, 16'hFFFF, 1'b1, a_r, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) begin
            exp_rd = ((i % 9) != 8);
            @(negedge clk_in);
            expectReady("starve", !exp_rd, exp_rd);
            waitCycle();
            checkOutput("starve cmd", 128'(mem_cmd_out), 128'(exp_rd));
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();

        // Write pass-through, read zeroing, zero-strobe write
        applyStimulus(1'b1, a4, d4, 16'h00F0, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk_in);
        expectReady("wr single", 1'b1, 1'b0);
        waitCycle();
        expectMem("wr single", 1'b1, 1'b0, 27'(a4), d4, 16'h00F0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, a_r, 1'b0, 1'b1);
        @(negedge clk_in);
        expectReady("rd single", 1'b0, 1'b1);
        waitCycle();
        expectMem("rd single", 1'b1, 1'b1, 27'(a_r), 128'h0, 16'h0);
        applyStimulus(1'b1, a5, d5, 16'h0000, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();
        expectMem("wr zero strobe", 1'b1, 1'b0, 27'(a5), d5, 16'h0000);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();
        checkOutput("idle valid", 128'(mem_valid_out), 128'(1'b0));

        // Back-pressure: held write stays stable, no grants, drains in order
        applyStimulus(1'b1, a6, d6, 16'h0F0F, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b1, a7, d7, 16'hFFFF, 1'b1, a8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            expectReady("stall", 1'b0, 1'b0);
            waitCycle();
            expectMem("stall", 1'b1, 1'b0, 27'(a6), d6, 16'h0F0F);
        end
        mem_ready_in = 1'b1;
        @(negedge clk_in);
        expectReady("drain rd", 1'b0, 1'b1);
        waitCycle();
        expectMem("drain rd", 1'b1, 1'b1, 27'(a8), 128'h0, 16'h0);
        applyStimulus(1'b1, a7, d7, 16'hFFFF, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk_in);
        expectReady("drain wr", 1'b1, 1'b0);
        waitCycle();
        expectMem("drain wr", 1'b1, 1'b0, 27'(a7), d7, 16'hFFFF);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();

        // Async reset mid-transfer; round robin history returns to READ
        applyStimulus(1'b1, a5, d5, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0);
        waitCycle();
        checkOutput("pre-reset valid", 128'(mem_valid_out), 128'(1'b1));
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        expectMem("async reset", 1'b0, 1'b0, 27'h0, 128'h0, 16'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        applyStimulus(1'b1, a_w, d_w, 16'hFFFF, 1'b1, a_r, 1'b0, 1'b1);
        #1;
        expectReady("post-reset", 1'b1, 1'b0);
        waitCycle();
        expectMem("post-reset", 1'b1, 1'b0, 27'(a_w), d_w, 16'hFFFF);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();

`ifdef FB_CLEAR_EN
        // Clear sweep with an urgent read injected after the third chunk
        clear_start_in = 1'b1;
        @(negedge clk_in);
        checkOutput("clear busy before", 128'(clear_busy_out), 128'(1'b0));
        waitCycle();
        clear_start_in = 1'b0;
        checkOutput("clear busy start", 128'(clear_busy_out), 128'(1'b1));
        exp_ptr = 0;
        for (int idx = 0; idx < NCHUNK + 1; idx++) begin
            if (idx == 3) applyStimulus(1'b1, a_w, d_w, 16'hFFFF, 1'b1, a_r, 1'b1, 1'b1);
            else          applyStimulus(1'b1, a_w, d_w, 16'hFFFF, 1'b0, '0, 1'b0, 1'b1);
            @(negedge clk_in);
            if (idx == 3) begin
                expectReady("clear rd", 1'b0, 1'b1);
                checkOutput("clear rd done", 128'(clear_done_out), 128'(1'b0));
                waitCycle();
                expectMem("clear rd", 1'b1, 1'b1, 27'(a_r), 128'h0, 16'h0);
            end else begin
                expectReady("clear wr", 1'b0, 1'b0);
                checkOutput("clear done", 128'(clear_done_out),
                            128'(exp_ptr == NCHUNK - 1));
                waitCycle();
                expectMem("clear wr", 1'b1, 1'b0, 27'(exp_ptr), {8{CLEAR_PIX}}, 16'hFFFF);
                exp_ptr++;
                checkOutput("clear busy", 128'(clear_busy_out), 128'(exp_ptr != NCHUNK));
            end
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        waitCycle();
`else
        // Without the clear engine the start pulse does nothing
        clear_start_in = 1'b1;
        @(negedge clk_in);
        checkOutput("no clear done", 128'(clear_done_out), 128'(1'b0));
        waitCycle();
        clear_start_in = 1'b0;
        checkOutput("no clear busy", 128'(clear_busy_out), 128'(1'b0));
        checkOutput("no clear valid", 128'(mem_valid_out), 128'(1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
